// File: rtl/nn_pkg.sv
// Shared constants and encodings for the NN pattern feeder.
// Word width, stream length, response timeout, FSM states and load-target selects.
package nn_pkg;

  localparam int NN_DATA_W  = 32;
  localparam int NN_N_ELEM  = 9;
  localparam int NN_TIMEOUT = 300;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RECV = 2'd3
  } state_t;

  localparam logic [1:0] SEL_U = 2'd0;
  localparam logic [1:0] SEL_W = 2'd1;
  localparam logic [1:0] SEL_V = 2'd2;
  localparam logic [1:0] SEL_X = 2'd3;

endpackage

// File: rtl/nn_feeder_buf.sv
// One pattern stream buffer: N_ELEM words written in order through a
// saturating pointer, with a full flag and an indexed combinational read.
module nn_feeder_buf
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W,
  parameter int N_ELEM = NN_N_ELEM,
  parameter int PTR_W  = $clog2(NN_N_ELEM + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic              full
);

  logic [DATA_W-1:0] mem_r [N_ELEM];
  logic [PTR_W-1:0]  ptr_r;
  logic              wr_ok_s;

  assign full    = (ptr_r == PTR_W'(N_ELEM));
  assign wr_ok_s = wr_en & ~full;

  // write pointer: cleared after a completed transaction, saturates at N_ELEM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_r <= PTR_W'(0);
    end else if (clr) begin
      ptr_r <= PTR_W'(0);
    end else if (wr_ok_s) begin
      ptr_r <= ptr_r + PTR_W'(1);
    end
  end

  // storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[ptr_r] <= wr_data;
    end
  end

  // indexed read, zero outside the stored range
  always_comb begin
    if (rd_idx < PTR_W'(N_ELEM)) begin
      rd_data = mem_r[rd_idx];
    end else begin
      rd_data = DATA_W'(0);
    end
  end

endmodule

// File: rtl/nn_feeder.sv
// NN pattern feeder: buffers one U/W/V/X pattern from the host, streams it to
// the NN core, then collects the N_ELEM-beat result with a response timeout.
module nn_feeder
  import nn_pkg::*;
#(
  parameter int DATA_W  = NN_DATA_W,
  parameter int N_ELEM  = NN_N_ELEM,
  parameter int TIMEOUT = NN_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_valid,
  input  logic [1:0]               ld_sel,
  input  logic [DATA_W-1:0]        ld_data,
  output logic                     ld_ready,
  input  logic                     start,
  output logic                     busy,
  output logic                     in_valid_u,
  output logic                     in_valid_w,
  output logic                     in_valid_v,
  output logic                     in_valid_x,
  output logic [DATA_W-1:0]        weight_u,
  output logic [DATA_W-1:0]        weight_w,
  output logic [DATA_W-1:0]        weight_v,
  output logic [DATA_W-1:0]        data_x,
  input  logic                     out_valid,
  input  logic [DATA_W-1:0]        out,
  output logic [DATA_W*N_ELEM-1:0] res_data,
  output logic                     done,
  output logic                     timeout
);

  localparam int ELEM_W = $clog2(N_ELEM + 1);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_t             state_r, state_nxt_s;
  logic [ELEM_W-1:0]  elem_r, elem_nxt_s;
  logic [ELEM_W-1:0]  idx_r, idx_nxt_s;
  logic [CNT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
  logic               timeout_r, timeout_nxt_s;
  logic               done_r, done_nxt_s;
  logic               send_nxt_s;
  logic               clr_ptr_s;
  logic               cap_en_s;
  logic [ELEM_W-1:0]  cap_idx_s;
  logic [3:0]         wr_en_s;
  logic [3:0]         full_s;
  logic [DATA_W-1:0]  rd_u_s, rd_w_s, rd_v_s, rd_x_s;
  logic               in_valid_r;
  logic               busy_r, ld_ready_r;
  logic [DATA_W-1:0]  weight_u_r, weight_w_r, weight_v_r, data_x_r;
  logic [DATA_W-1:0]  res_r [N_ELEM];

  // host writes are steered to one buffer, and only while idle
  always_comb begin
    wr_en_s = 4'b0000;
    if ((state_r == IDLE) && ld_valid) begin
      case (ld_sel)
        SEL_U:   wr_en_s = 4'b0001;
        SEL_W:   wr_en_s = 4'b0010;
        SEL_V:   wr_en_s = 4'b0100;
        SEL_X:   wr_en_s = 4'b1000;
        default: wr_en_s = 4'b0000;
      endcase
    end else begin
      wr_en_s = 4'b0000;
    end
  end

  nn_feeder_buf #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .PTR_W(ELEM_W)) u_buf_u (
    .clk(clk), .rst_n(rst_n), .clr(clr_ptr_s), .wr_en(wr_en_s[0]), .wr_data(ld_data),
    .rd_idx(elem_nxt_s), .rd_data(rd_u_s), .full(full_s[0]));

  nn_feeder_buf #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .PTR_W(ELEM_W)) u_buf_w (
    .clk(clk), .rst_n(rst_n), .clr(clr_ptr_s), .wr_en(wr_en_s[1]), .wr_data(ld_data),
    .rd_idx(elem_nxt_s), .rd_data(rd_w_s), .full(full_s[1]));

  nn_feeder_buf #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .PTR_W(ELEM_W)) u_buf_v (
    .clk(clk), .rst_n(rst_n), .clr(clr_ptr_s), .wr_en(wr_en_s[2]), .wr_data(ld_data),
    .rd_idx(elem_nxt_s), .rd_data(rd_v_s), .full(full_s[2]));

  nn_feeder_buf #(.DATA_W(DATA_W), .N_ELEM(N_ELEM), .PTR_W(ELEM_W)) u_buf_x (
    .clk(clk), .rst_n(rst_n), .clr(clr_ptr_s), .wr_en(wr_en_s[3]), .wr_data(ld_data),
    .rd_idx(elem_nxt_s), .rd_data(rd_x_s), .full(full_s[3]));

  // next-state, counters, capture strobes and error/done decisions
  always_comb begin
    state_nxt_s    = state_r;
    elem_nxt_s     = elem_r;
    idx_nxt_s      = idx_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_nxt_s  = timeout_r;
    done_nxt_s     = 1'b0;
    send_nxt_s     = 1'b0;
    clr_ptr_s      = 1'b0;
    cap_en_s       = 1'b0;
    cap_idx_s      = idx_r;
    case (state_r)
      IDLE: begin
        // start sees the pointers as they were before any same-cycle write
        if (start && (&full_s)) begin
          state_nxt_s   = SEND;
          elem_nxt_s    = ELEM_W'(0);
          send_nxt_s    = 1'b1;
          timeout_nxt_s = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (out_valid) begin
          timeout_nxt_s = 1'b1;
        end else begin
          timeout_nxt_s = timeout_r;
        end
        if (elem_r == ELEM_W'(N_ELEM - 1)) begin
          elem_nxt_s = ELEM_W'(0);
          if (timeout_r || out_valid) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s    = WAIT;
            wait_cnt_nxt_s = CNT_W'(0);
          end
        end else begin
          elem_nxt_s = elem_r + ELEM_W'(1);
          send_nxt_s = 1'b1;
        end
      end
      WAIT: begin
        if (out_valid) begin
          cap_en_s    = 1'b1;
          cap_idx_s   = ELEM_W'(0);
          idx_nxt_s   = ELEM_W'(1);
          state_nxt_s = RECV;
        end else if (wait_cnt_r == CNT_W'(TIMEOUT - 1)) begin
          timeout_nxt_s = 1'b1;
          state_nxt_s   = IDLE;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1);
        end
      end
      RECV: begin
        if (out_valid) begin
          cap_en_s  = 1'b1;
          cap_idx_s = idx_r;
          if (idx_r == ELEM_W'(N_ELEM - 1)) begin
            done_nxt_s  = 1'b1;
            clr_ptr_s   = 1'b1;
            idx_nxt_s   = ELEM_W'(0);
            state_nxt_s = IDLE;
          end else begin
            idx_nxt_s = idx_r + ELEM_W'(1);
          end
        end else begin
          idx_nxt_s = idx_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM state, counters and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      elem_r     <= ELEM_W'(0);
      idx_r      <= ELEM_W'(0);
      wait_cnt_r <= CNT_W'(0);
      timeout_r  <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      ld_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      elem_r     <= elem_nxt_s;
      idx_r      <= idx_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      timeout_r  <= timeout_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= (state_nxt_s != IDLE);
      ld_ready_r <= (state_nxt_s == IDLE);
    end
  end

  // NN-side beat registers: element k is presented in SEND cycle k, zero otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_valid_r <= 1'b0;
      weight_u_r <= DATA_W'(0);
      weight_w_r <= DATA_W'(0);
      weight_v_r <= DATA_W'(0);
      data_x_r   <= DATA_W'(0);
    end else if (send_nxt_s) begin
      in_valid_r <= 1'b1;
      weight_u_r <= rd_u_s;
      weight_w_r <= rd_w_s;
      weight_v_r <= rd_v_s;
      data_x_r   <= rd_x_s;
    end else begin
      in_valid_r <= 1'b0;
      weight_u_r <= DATA_W'(0);
      weight_w_r <= DATA_W'(0);
      weight_v_r <= DATA_W'(0);
      data_x_r   <= DATA_W'(0);
    end
  end

  // result capture, one word per accepted out_valid beat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N_ELEM; k++) begin
        res_r[k] <= DATA_W'(0);
      end
    end else if (cap_en_s) begin
      res_r[cap_idx_s] <= out;
    end
  end

  for (genvar g = 0; g < N_ELEM; g++) begin : g_res
    assign res_data[g*DATA_W +: DATA_W] = res_r[g];
  end

  assign in_valid_u = in_valid_r;
  assign in_valid_w = in_valid_r;
  assign in_valid_v = in_valid_r;
  assign in_valid_x = in_valid_r;
  assign weight_u   = weight_u_r;
  assign weight_w   = weight_w_r;
  assign weight_v   = weight_v_r;
  assign data_x     = data_x_r;
  assign busy       = busy_r;
  assign ld_ready   = ld_ready_r;
  assign done       = done_r;
  assign timeout    = timeout_r;

endmodule
